// File: rtl/usb_pkg.sv
// Shared PID codes, completion status and FSM state encoding for the USB
// host transaction engine.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {
    ST_OK         = 2'b00,
    ST_RETRY_FAIL = 2'b01,
    ST_STALL      = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    IDLE,
    TOKEN,
    DATA_TX,
    HS_WAIT,
    DATA_WAIT,
    HS_TX,
    FIN
  } state_e;

endpackage

// File: rtl/usb_timeout_ctr.sv
// Wait-state timeout counter: cleared while idle, expires in the
// TIMEOUT_CYCLES-th enabled cycle.
module usb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/usb_txn_engine.sv
// Host-side USB OUT/IN transaction engine with per-endpoint data toggles.
// Build option USB_STALL_EN: a STALL handshake ends the transaction with status STALL.
module usb_txn_engine
  import usb_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int NUM_EP         = 16,
  parameter int MAX_RETRY      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dir,
  input  logic [6:0]        req_addr,
  input  logic [3:0]        req_endp,
  input  logic [DATA_W-1:0] req_data,
  input  logic              tgl_clr,
  input  logic [3:0]        tgl_endp,
  output logic              enc_valid,
  input  logic              enc_ready,
  output logic [3:0]        enc_pid,
  output logic [6:0]        enc_addr,
  output logic [3:0]        enc_endp,
  output logic [DATA_W-1:0] enc_data,
  input  logic              dec_valid,
  input  logic              dec_ok,
  input  logic [3:0]        dec_pid,
  input  logic [DATA_W-1:0] dec_data,
  output logic              done,
  output logic [1:0]        status,
  output logic [DATA_W-1:0] rd_data
);

  state_e            state, state_n;
  status_e           status_q;
  logic              dir_q, discard_q, cur_tgl;
  logic [6:0]        addr_q;
  logic [3:0]        endp_q, retry_q, retry_inc;
  logic [DATA_W-1:0] data_q, rd_q;
  logic [NUM_EP-1:0] tgl_q;
  logic              capture, flip, fail, give_up, fin_ok, fin_stall, latch_rd, to_hs;
  logic              in_wait, expired;
  logic [3:0]        exp_pid, alt_pid;

  assign in_wait   = (state == HS_WAIT) || (state == DATA_WAIT);
  assign retry_inc = retry_q + 4'd1;
  assign give_up   = (retry_inc == 4'(MAX_RETRY));
  assign exp_pid   = cur_tgl ? PID_DATA1 : PID_DATA0;
  assign alt_pid   = cur_tgl ? PID_DATA0 : PID_DATA1;

  usb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr    (!in_wait),
    .en     (in_wait),
    .expired(expired)
  );

  always_comb begin
    cur_tgl = 1'b0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (endp_q == 4'(i)) cur_tgl = tgl_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    enc_valid = 1'b0;
    enc_pid   = 4'd0;
    enc_addr  = 7'd0;
    enc_endp  = 4'd0;
    enc_data  = '0;
    capture   = 1'b0;
    flip      = 1'b0;
    fail      = 1'b0;
    fin_ok    = 1'b0;
    fin_stall = 1'b0;
    latch_rd  = 1'b0;
    to_hs     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture = 1'b1;
          state_n = TOKEN;
        end
      end
      TOKEN: begin
        enc_valid = 1'b1;
        enc_pid   = dir_q ? PID_IN : PID_OUT;
        enc_addr  = addr_q;
        enc_endp  = endp_q;
        if (enc_ready) state_n = dir_q ? DATA_WAIT : DATA_TX;
      end
      DATA_TX: begin
        enc_valid = 1'b1;
        enc_pid   = exp_pid;
        enc_data  = data_q;
        if (enc_ready) state_n = HS_WAIT;
      end
      HS_WAIT: begin
        if (dec_valid) begin
          if (dec_ok && dec_pid == PID_ACK) begin
            flip    = 1'b1;
            fin_ok  = 1'b1;
            state_n = FIN;
          end
`ifdef USB_STALL_EN
          else if (dec_ok && dec_pid == PID_STALL) begin
            fin_stall = 1'b1;
            state_n   = FIN;
          end
`endif
          else fail = 1'b1;
        end else if (expired) begin
          fail = 1'b1;
        end
      end
      DATA_WAIT: begin
        // A stale-toggle DATA is still ACKed so the device advances, but its payload is dropped.
        if (dec_valid) begin
          if (dec_ok && dec_pid == exp_pid) begin
            latch_rd = 1'b1;
            flip     = 1'b1;
            to_hs    = 1'b1;
            state_n  = HS_TX;
          end else if (dec_ok && dec_pid == alt_pid) begin
            to_hs   = 1'b1;
            state_n = HS_TX;
          end
`ifdef USB_STALL_EN
          else if (dec_ok && dec_pid == PID_STALL) begin
            fin_stall = 1'b1;
            state_n   = FIN;
          end
`endif
          else fail = 1'b1;
        end else if (expired) begin
          fail = 1'b1;
        end
      end
      HS_TX: begin
        enc_valid = 1'b1;
        enc_pid   = PID_ACK;
        if (enc_ready) begin
          if (discard_q) begin
            fail = 1'b1;
          end else begin
            fin_ok  = 1'b1;
            state_n = FIN;
          end
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (fail) state_n = give_up ? FIN : TOKEN;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dir_q     <= 1'b0;
      addr_q    <= 7'd0;
      endp_q    <= 4'd0;
      data_q    <= '0;
      rd_q      <= '0;
      retry_q   <= 4'd0;
      discard_q <= 1'b0;
      status_q  <= ST_OK;
    end else begin
      if (capture) begin
        dir_q    <= req_dir;
        addr_q   <= req_addr;
        endp_q   <= req_endp;
        data_q   <= req_data;
        retry_q  <= 4'd0;
        status_q <= ST_OK;
      end else if (fail) begin
        retry_q <= retry_inc;
        if (give_up) status_q <= ST_RETRY_FAIL;
      end else if (fin_stall) begin
        status_q <= ST_STALL;
      end else if (fin_ok) begin
        status_q <= ST_OK;
      end
      if (latch_rd) rd_q <= dec_data;
      if (to_hs) discard_q <= !latch_rd;
    end
  end

  // An explicit clear beats a simultaneous toggle flip on the same endpoint.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tgl_q <= '0;
    end else begin
      for (int i = 0; i < NUM_EP; i++) begin
        if (tgl_clr && tgl_endp == 4'(i))     tgl_q[i] <= 1'b0;
        else if (flip && endp_q == 4'(i))     tgl_q[i] <= ~tgl_q[i];
      end
    end
  end

  assign done    = (state == FIN);
  assign status  = done ? status_q : 2'b00;
  assign rd_data = (done && dir_q && status_q == ST_OK) ? rd_q : '0;

endmodule
